// File: rtl/mem_loader.sv
// Host-side initiator for the 16x4 register memory: LOAD streams nibbles in, DUMP streams them out.
// Optional running checksum of loaded nibbles is enabled by defining LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int MEMORY_REGISTERS     = 16,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            load_start_i,
    input  logic                            dump_start_i,
    input  logic                            in_valid_i,
    input  logic [REGISTER_WIDTH-1:0]       in_data_i,
    output logic                            in_ready_o,
    output logic                            out_valid_o,
    output logic [REGISTER_WIDTH-1:0]       out_data_o,
    input  logic                            out_ready_i,
    output logic                            mem_write_en_o,
    output logic                            mem_read_en_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]       mem_data_o,
    input  logic [REGISTER_WIDTH-1:0]       mem_data_i,
    output logic                            cpu_halt_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [REGISTER_WIDTH-1:0]       checksum_o,
    output logic [1:0]                      dbg_state
);
    localparam int AW = MEMORY_ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_REGISTERS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        DUMP_RD  = 2'd2,
        DUMP_OUT = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          in_fire;
    logic          out_fire;

    // Handshakes: a beat moves on a rising edge where valid && ready are both 1.
    // Valid, once raised, holds with its data stable until that edge; ready may change freely.
    assign in_fire  = (state == LOAD) && in_valid_i;
    assign out_fire = (state == DUMP_OUT) && out_ready_i;

`ifdef LOADER_CHECKSUM_EN
    logic [REGISTER_WIDTH-1:0] checksum;
    assign checksum_o = checksum;
`else
    assign checksum_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            out_data_o <= '0;
            done_o     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (load_start_i) begin
                        state <= LOAD;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end else if (dump_start_i) begin
                        state <= DUMP_RD;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum + in_data_i;
`endif
                        if (cnt == LAST_ADDR) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            done_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DUMP_RD: begin
                    out_data_o <= mem_data_i;
                    state      <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_fire) begin
                        if (cnt == LAST_ADDR) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            done_o <= 1'b1;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= DUMP_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes decode from state so they can never overlap and are quiet in IDLE.
    assign in_ready_o     = (state == LOAD);
    assign out_valid_o    = (state == DUMP_OUT);
    assign mem_write_en_o = in_fire;
    assign mem_read_en_o  = (state == DUMP_RD);
    assign mem_addr_o     = cnt;
    assign mem_data_o     = in_fire ? in_data_i : '0;
    assign cpu_halt_o     = (state != IDLE);
    assign busy_o         = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table-driven LOAD/DUMP vectors plus hand-written
// sequences for stalls, start-pulse priority, mid-load reset and the checksum.
module tb_mem_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       dump_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic       mem_write_en;
  logic       mem_read_en;
  logic [3:0] mem_addr;
  logic [3:0] mem_data;
  logic [3:0] mem_rdata;
  logic       cpu_halt;
  logic       busy;
  logic       done;
  logic [3:0] checksum;
  logic [1:0] dbg_state;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] SUM_T1 = 4'hB;
  localparam logic [3:0] SUM_T6 = 4'h8;
`else
  localparam logic [3:0] SUM_T1 = 4'h0;
  localparam logic [3:0] SUM_T6 = 4'h0;
`endif

  mem_loader dut (
    .clk_i(clk), .reset_i(reset),
    .load_start_i(load_start), .dump_start_i(dump_start),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .mem_write_en_o(mem_write_en), .mem_read_en_o(mem_read_en),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_data_i(mem_rdata),
    .cpu_halt_o(cpu_halt), .busy_o(busy), .done_o(done),
    .checksum_o(checksum), .dbg_state(dbg_state)
  );

  // clock / memory model / reset block
  always #5 clk = ~clk;

  logic [3:0] mem [16];
  int n_wr = 0;
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr] <= mem_data;
      n_wr++;
    end
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {in_ready, out_valid, out_data, mem_write_en, mem_read_en,
            mem_addr, mem_data, cpu_halt, busy, done};
  endfunction

  function automatic logic [18:0] ex(input logic ir, input logic ov, input logic [3:0] od,
                                     input logic we, input logic re, input logic [3:0] ad,
                                     input logic [3:0] md, input logic h, input logic dn);
    return {ir, ov, od, we, re, ad, md, h, h, dn};
  endfunction

  typedef struct {
    logic       ls;
    logic       ds;
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ls, input logic ds, input logic iv, input logic [3:0] id,
                         input logic ordy, input logic [18:0] exp);
    vec_t v;
    v.ls = ls; v.ds = ds; v.iv = iv; v.id = id; v.ordy = ordy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      load_start = vecs[i].ls; dump_start = vecs[i].ds;
      in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      #1;
      check("vec", i, 32'(obs()), 32'(vecs[i].exp));
    end
  endtask

  task automatic load_beats(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 4'(base + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [3:0] d1 [16];
  logic [3:0] d3 [16];
  logic [3:0] exp_v;
  int wr, cyc, w, wr_base;

  initial begin
    for (int i = 0; i < 16; i++) begin
      d1[i] = 4'h0;
      d3[i] = 4'((i * 7 + 3) % 16);
    end
    d1[0] = 4'hE; d1[1] = 4'h5; d1[2] = 4'h8;

    // test 1: straight LOAD, then test 2: straight DUMP
    add_vec(1, 0, 0, 4'h0, 0, ex(0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0));
    for (int k = 0; k < 16; k++)
      add_vec(0, 0, 1, d1[k], 0, ex(1, 0, 4'h0, 1, 0, 4'(k), d1[k], 1, 0));
    add_vec(0, 0, 0, 4'h0, 0, ex(0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1));
    add_vec(0, 0, 0, 4'h0, 0, ex(0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0));
    add_vec(0, 1, 0, 4'h0, 1, ex(0, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      add_vec(0, 0, 0, 4'h0, 1, ex(0, 0, (i == 0) ? 4'h0 : d1[i-1], 0, 1, 4'(i), 4'h0, 1, 0));
      add_vec(0, 0, 0, 4'h0, 1, ex(0, 1, d1[i], 0, 0, 4'(i), 4'h0, 1, 0));
    end
    add_vec(0, 0, 0, 4'h0, 0, ex(0, 0, d1[15], 0, 0, 4'h0, 4'h0, 0, 1));
    add_vec(0, 0, 0, 4'h0, 0, ex(0, 0, d1[15], 0, 0, 4'h0, 4'h0, 0, 0));

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outputs", 0, 32'(obs()), 32'(0));
    check("reset_checksum", 0, 32'(checksum), 32'(0));
    check("reset_state", 0, 32'(dbg_state), 32'(0));

    run_vectors();
    check("t1_checksum", 0, 32'(checksum), 32'(SUM_T1));

    // test 3: gappy LOAD, stalled DUMP
    wr_base = n_wr;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    wr = 0; cyc = 0;
    while (wr < 16 && cyc < 100) begin
      in_valid = ((cyc % 3) != 2);
      in_data = d3[wr];
      #1;
      check("t3_strobe", cyc, 32'(mem_write_en), 32'(in_valid));
      if (mem_write_en) begin
        check("t3_wr_addr", wr, 32'(mem_addr), 32'(wr));
        check("t3_wr_data", wr, 32'(mem_data), 32'(d3[wr]));
        exp_q.push_back(d3[wr]);
        wr++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("t3_load_count", 0, 32'(wr), 32'(16));
    check("t3_load_done", 0, 32'(done), 32'(1));

    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hX;
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("t3_out_valid", b, 32'(out_valid), 32'(1));
      for (int s = 0; s < 3; s++) begin
        check("t3_stall_data", b, 32'(out_data), 32'(exp_v));
        @(negedge clk);
        check("t3_stall_valid", b, 32'(out_valid), 32'(1));
      end
      out_ready = 1'b1;
      check("t3_out_data", b, 32'(out_data), 32'(exp_v));
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("t3_dump_done", 0, 32'(done), 32'(1));
    check("t3_write_total", 0, 32'(n_wr - wr_base), 32'(16));

    // test 4: simultaneous starts, dump_start ignored in LOAD; test 6 checksum
    @(negedge clk); load_start = 1'b1; dump_start = 1'b1;
    @(negedge clk); load_start = 1'b0; dump_start = 1'b1;
    #1;
    check("t4_load_wins", 0, 32'(in_ready), 32'(1));
    check("t4_no_read", 0, 32'(mem_read_en), 32'(0));
    @(negedge clk); dump_start = 1'b0;
    #1;
    check("t4_ignore_dump", 0, 32'(dbg_state), 32'(1));
    check("t4_no_read2", 0, 32'(mem_read_en), 32'(0));
    load_beats(16, 1);
    #1;
    check("t4_done", 0, 32'(done), 32'(1));
    check("t6_checksum", 0, 32'(checksum), 32'(SUM_T6));
    check("t4_mem15", 0, 32'(mem[15]), 32'(0));

    // test 5: reset after 5 LOAD beats
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data = 4'(9 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_outputs", 0, 32'(obs()), 32'(0));
    check("t5_checksum", 0, 32'(checksum), 32'(0));
    check("t5_state", 0, 32'(dbg_state), 32'(0));
    for (int k = 0; k < 5; k++)
      check("t5_mem_new", k, 32'(mem[k]), 32'(9 + k));
    check("t5_mem_kept", 5, 32'(mem[5]), 32'(6));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
